// File: rtl/prm_obstacle_feeder.sv
// ---------------------------------------------------------------------------
// prm_obstacle_feeder
//
// Feeds a per-frame stream of obstacle codes to a bank of combinational PRM
// edge checkers. It ORs the returned edge masks into a sticky blocked-edge
// bitmap. At the end of the frame it hands that bitmap, with the number of
// accepted codes, to the roadmap search logic.
//
// Optional feature (macro PRM_FEEDER_POPCNT_EN):
//   Adds res_nblk, the population count of res_blocked. It is registered in
//   the same cycle as res_blocked.
//
// Ports:
//   clk            single clock, rising edge
//   rst            asynchronous, active-high reset
//   obs_valid      obstacle code valid
//   obs_ready      feeder can accept a code (registered)
//   obs_code       obstacle code; bit0 = checker input A, bit14 = input O
//   obs_last       last code of the frame, qualified by obs_valid
//   chk_code       registered code driven to every checker's A..O inputs
//   chk_edge_mask  checker outputs, bit i = edge i, combinational from chk_code
//   res_valid      blocked bitmap valid
//   res_ready      consumer accepts bitmap
//   res_blocked    1 = edge collides with at least one obstacle in the frame
//   res_count      number of codes accepted in the frame (saturating)
//   res_nblk       popcount of res_blocked (only with PRM_FEEDER_POPCNT_EN)
//   state_dbg      current FSM state (0 = RUN, 1 = FLUSH, 2 = OUT)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Once a valid is raised, its payload is held until that transfer
// occurs. Ready may be high without valid and is then ignored.
// ---------------------------------------------------------------------------
module prm_obstacle_feeder #(
  parameter int CODE_W    = 15,
  parameter int NUM_EDGES = 64,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 obs_valid,
  output logic                 obs_ready,
  input  logic [CODE_W-1:0]    obs_code,
  input  logic                 obs_last,
  output logic [CODE_W-1:0]    chk_code,
  input  logic [NUM_EDGES-1:0] chk_edge_mask,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [NUM_EDGES-1:0] res_blocked,
  output logic [CNT_W-1:0]     res_count,
`ifdef PRM_FEEDER_POPCNT_EN
  output logic [$clog2(NUM_EDGES+1)-1:0] res_nblk,
`endif
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  state_t                state, state_next;
  logic                  chk_vld;
  logic [NUM_EDGES-1:0]  acc;
  logic [CNT_W-1:0]      cnt;
  logic                  accept;
  logic [NUM_EDGES-1:0]  cap_mask;
  logic [NUM_EDGES-1:0]  final_blocked;

  assign state_dbg = state;
  assign accept    = obs_valid & obs_ready;
  // The mask on the checker outputs counts only in the cycle after a code
  // was accepted. A held chk_code on idle cycles contributes nothing.
  assign cap_mask      = chk_vld ? chk_edge_mask : '0;
  assign final_blocked = acc | cap_mask;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RUN;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_RUN:   if (accept && obs_last) state_next = S_FLUSH;
      S_FLUSH: state_next = S_OUT;
      S_OUT:   if (res_ready) state_next = S_RUN;
      default: state_next = S_RUN;
    endcase
  end

  // Datapath. obs_ready is registered from the next state, so it is low
  // throughout reset and rises on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      obs_ready   <= 1'b0;
      chk_code    <= '0;
      chk_vld     <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      res_valid   <= 1'b0;
      res_blocked <= '0;
      res_count   <= '0;
    end else begin
      obs_ready <= (state_next == S_RUN);

      if (state == S_OUT && res_ready) acc <= '0;
      else if (chk_vld)                acc <= final_blocked;

      case (state)
        S_RUN: begin
          if (accept) begin
            chk_code <= obs_code;
            chk_vld  <= 1'b1;
            if (cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
          end else begin
            chk_vld <= 1'b0;
          end
        end
        S_FLUSH: begin
          res_blocked <= final_blocked;
          res_count   <= cnt;
          res_valid   <= 1'b1;
          chk_vld     <= 1'b0;
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cnt       <= '0;
          end
        end
        default: chk_vld <= 1'b0;
      endcase
    end
  end

`ifdef PRM_FEEDER_POPCNT_EN
  localparam int NBLK_W = $clog2(NUM_EDGES+1);

  function automatic logic [NBLK_W-1:0] popcnt(input logic [NUM_EDGES-1:0] v);
    logic [NBLK_W-1:0] s;
    s = '0;
    for (int i = 0; i < NUM_EDGES; i++) s = s + NBLK_W'(v[i]);
    return s;
  endfunction

  // Loaded on the same edge as res_blocked, so it is valid with res_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  res_nblk <= '0;
    else if (state == S_FLUSH) res_nblk <= popcnt(final_blocked);
  end
`endif

endmodule

// File: tb/tb_prm_obstacle_feeder.sv
// ---------------------------------------------------------------------------
// tb_prm_obstacle_feeder
//
// Directed, table-driven bench for prm_obstacle_feeder with 8 edges and a
// 2-bit counter. The checker bank is modelled as a code -> mask lookup.
// Inputs are driven, and outputs sampled, on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_prm_obstacle_feeder;

  localparam int CODE_W    = 15;
  localparam int NUM_EDGES = 8;
  localparam int CNT_W     = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 obs_valid = 1'b0;
  logic                 obs_ready;
  logic [CODE_W-1:0]    obs_code  = '0;
  logic                 obs_last  = 1'b0;
  logic [CODE_W-1:0]    chk_code;
  logic [NUM_EDGES-1:0] chk_edge_mask;
  logic                 res_valid;
  logic                 res_ready = 1'b0;
  logic [NUM_EDGES-1:0] res_blocked;
  logic [CNT_W-1:0]     res_count;
  logic [1:0]           state_dbg;
`ifdef PRM_FEEDER_POPCNT_EN
  logic [$clog2(NUM_EDGES+1)-1:0] res_nblk;
`endif

  prm_obstacle_feeder #(
    .CODE_W(CODE_W), .NUM_EDGES(NUM_EDGES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .obs_valid(obs_valid), .obs_ready(obs_ready),
    .obs_code(obs_code), .obs_last(obs_last),
    .chk_code(chk_code), .chk_edge_mask(chk_edge_mask),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_blocked(res_blocked), .res_count(res_count),
`ifdef PRM_FEEDER_POPCNT_EN
    .res_nblk(res_nblk),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- checker-bank model ----------------
  function automatic logic [NUM_EDGES-1:0] chk_model(input logic [CODE_W-1:0] c);
    case (c)
      15'h0123: return 8'h05;
      15'h0000: return 8'h40;
      15'h0011: return 8'h01;
      15'h0022: return 8'h10;
      15'h0033: return 8'h00;
      15'h0044: return 8'h80;
      15'h0055: return 8'h02;
      15'h0066: return 8'h04;
      15'h0077: return 8'h08;
      15'h0088: return 8'hFF;
      15'h0099: return 8'h01;
      15'h00A1: return 8'hA0;
      15'h00A2: return 8'h13;
      default:  return 8'h00;
    endcase
  endfunction

  assign chk_edge_mask = chk_model(chk_code);

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [NUM_EDGES-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [2:0]             n;
    logic [4:0][CODE_W-1:0] code;
    logic                   gap;
    logic [3:0]             hold;
    logic [NUM_EDGES-1:0]   exp_blk;
    logic [CNT_W-1:0]       exp_cnt;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input int n, input logic [CODE_W-1:0] c0, c1, c2, c3, c4,
                              input bit gap, input int hold,
                              input logic [NUM_EDGES-1:0] blk, input int cnt);
    vec_t v;
    v.n = 3'(n);
    v.code[0] = c0; v.code[1] = c1; v.code[2] = c2; v.code[3] = c3; v.code[4] = c4;
    v.gap = gap;
    v.hold = 4'(hold);
    v.exp_blk = blk;
    v.exp_cnt = CNT_W'(cnt);
    return v;
  endfunction

  // ---------------- driver ----------------
  // Entered on a falling edge while the feeder is in RUN with obs_ready high
  task automatic run_frame(input vec_t v, input string tag);
    logic [NUM_EDGES-1:0] exp_blk, held_blk;
    logic [CNT_W-1:0]     held_cnt;
    exp_q.push_back(v.exp_blk);
    for (int k = 0; k < int'(v.n); k++) begin
      obs_valid = 1'b1;
      obs_code  = v.code[k];
      obs_last  = (k == int'(v.n) - 1);
      check({tag, " obs_ready before accept"}, 64'(obs_ready), 64'd1);
      @(negedge clk);
      check({tag, " chk_code"}, 64'(chk_code), 64'(v.code[k]));
      if (v.gap && k != int'(v.n) - 1) begin
        // Idle cycle: obs_last and a heavy code without obs_valid must be ignored
        obs_valid = 1'b0;
        obs_last  = 1'b1;
        obs_code  = 15'h0088;
        @(negedge clk);
        check({tag, " gap res_valid"}, 64'(res_valid), 64'd0);
        check({tag, " gap obs_ready"}, 64'(obs_ready), 64'd1);
      end
    end
    obs_valid = 1'b0;
    obs_last  = 1'b0;
    // FLUSH cycle (t+1)
    check({tag, " flush obs_ready"}, 64'(obs_ready), 64'd0);
    check({tag, " flush res_valid"}, 64'(res_valid), 64'd0);
    @(negedge clk);
    // OUT cycle (t+2)
    exp_blk = exp_q.pop_front();
    check({tag, " res_valid at t+2"}, 64'(res_valid), 64'd1);
    check({tag, " res_blocked"}, 64'(res_blocked), 64'(exp_blk));
    check({tag, " res_count"}, 64'(res_count), 64'(v.exp_cnt));
    check({tag, " out obs_ready"}, 64'(obs_ready), 64'd0);
`ifdef PRM_FEEDER_POPCNT_EN
    check({tag, " res_nblk"}, 64'(res_nblk), 64'($countones(exp_blk)));
`endif
    held_blk = res_blocked;
    held_cnt = res_count;
    for (int h = 0; h < int'(v.hold); h++) begin
      @(negedge clk);
      check({tag, " hold res_valid"}, 64'(res_valid), 64'd1);
      check({tag, " hold res_blocked"}, 64'(res_blocked), 64'(held_blk));
      check({tag, " hold res_count"}, 64'(res_count), 64'(held_cnt));
      check({tag, " hold obs_ready"}, 64'(obs_ready), 64'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, " post-handshake res_valid"}, 64'(res_valid), 64'd0);
    check({tag, " post-handshake obs_ready"}, 64'(obs_ready), 64'd1);
  endtask

  // ---------------- test ----------------
  initial begin
    //                  n  codes                                         gap hold blk    cnt
    vecs[0] = mk(1, 15'h0123, 15'h0,    15'h0,    15'h0,    15'h0,    0, 0, 8'h05, 1);
    vecs[1] = mk(3, 15'h0011, 15'h0022, 15'h0033, 15'h0,    15'h0,    0, 5, 8'h11, 3);
    vecs[2] = mk(1, 15'h0044, 15'h0,    15'h0,    15'h0,    15'h0,    0, 0, 8'h80, 1);
    vecs[3] = mk(3, 15'h0055, 15'h0066, 15'h0077, 15'h0,    15'h0,    1, 0, 8'h0E, 3);
    vecs[4] = mk(1, 15'h0000, 15'h0,    15'h0,    15'h0,    15'h0,    0, 0, 8'h40, 1);
    vecs[5] = mk(5, 15'h0011, 15'h0022, 15'h0044, 15'h0055, 15'h0066, 0, 0, 8'h97, 3);
    vecs[6] = mk(2, 15'h00A1, 15'h00A2, 15'h0,    15'h0,    15'h0,    0, 1, 8'hB3, 2);
    vecs[7] = mk(1, 15'h0099, 15'h0,    15'h0,    15'h0,    15'h0,    0, 0, 8'h01, 1);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst obs_ready", 64'(obs_ready), 64'd0);
    check("rst res_valid", 64'(res_valid), 64'd0);
    check("rst res_blocked", 64'(res_blocked), 64'd0);
    check("rst res_count", 64'(res_count), 64'd0);
    check("rst chk_code", 64'(chk_code), 64'd0);
    check("rst state", 64'(state_dbg), 64'd0);
    rst = 1'b0;
    // res_ready without res_valid is ignored
    res_ready = 1'b1;
    @(negedge clk);
    check("idle obs_ready", 64'(obs_ready), 64'd1);
    @(negedge clk);
    check("idle res_valid", 64'(res_valid), 64'd0);
    res_ready = 1'b0;

    for (int i = 0; i < 7; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Reset mid-frame: two heavy codes, no obs_last, then reset
    for (int k = 0; k < 2; k++) begin
      obs_valid = 1'b1;
      obs_code  = 15'h0088;
      obs_last  = 1'b0;
      @(negedge clk);
    end
    obs_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("midframe res_valid", 64'(res_valid), 64'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst obs_ready", 64'(obs_ready), 64'd0);
    check("midrst res_valid", 64'(res_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("after rst obs_ready", 64'(obs_ready), 64'd1);
    run_frame(vecs[7], "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
